dtlb_lookup: RTL

Small fully-associative data TLB that sits directly upstream of the event counter block. It translates virtual page numbers to physical page numbers, refills from a page walker on a miss, and prefetches the next sequential page after each refill. It drives the `tlb_hit`, `tlb_miss` and `tlb_prefetch` event lines that the counter block edge-detects. Every event is a single-cycle pulse followed by at least one low cycle, so each event is counted exactly once.

---
 rtl/dtlb_lookup.sv | 125 ++++++++++++
 1 files changed

// File: rtl/dtlb_lookup.sv
// Fully-associative data TLB with round-robin replacement, demand walks and
// next-page prefetch; drives single-cycle hit/miss/prefetch event pulses.
module dtlb_lookup #(
   parameter int ENTRIES = 8,
   parameter int VPN_W   = 20,
   parameter int PPN_W   = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [VPN_W-1:0] req_vpn,
   output logic             resp_valid,
   output logic [PPN_W-1:0] resp_ppn,
   output logic             walk_req_valid,
   output logic [VPN_W-1:0] walk_req_vpn,
   output logic             walk_req_prefetch,
   input  logic             walk_resp_valid,
   input  logic [PPN_W-1:0] walk_resp_ppn,
   output logic             tlb_hit,
   output logic             tlb_miss,
   output logic             tlb_prefetch
);

   localparam int IDX_W = $clog2(ENTRIES);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, WALK, RESP, PREF, PWALK
   } state_t;

   state_t             state, state_nxt;
   logic [ENTRIES-1:0] valid;
   logic [VPN_W-1:0]   vpn_mem [ENTRIES];
   logic [PPN_W-1:0]   ppn_mem [ENTRIES];
   logic [IDX_W-1:0]   vptr;
   logic [VPN_W-1:0]   cur_vpn;
   logic [VPN_W-1:0]   pf_vpn;
   logic [PPN_W-1:0]   ppn_q;

   logic               hit;
   logic [PPN_W-1:0]   hit_ppn;
   logic [VPN_W-1:0]   cmp_vpn;
   logic               install;
   logic [VPN_W-1:0]   install_vpn;

   assign pf_vpn  = cur_vpn + 1'b1;
   assign cmp_vpn = (state == PREF) ? pf_vpn : cur_vpn;

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      hit     = 1'b0;
      hit_ppn = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && vpn_mem[i] == cmp_vpn) begin
            hit     = 1'b1;
            hit_ppn = ppn_mem[i];
         end
      end
   end

   always_comb begin
      install     = 1'b0;
      install_vpn = cur_vpn;
      state_nxt   = state;
      case (state)
         IDLE:   if (req_valid) state_nxt = LOOKUP;
         LOOKUP: state_nxt = hit ? IDLE : WALK;
         WALK: begin
            if (walk_resp_valid) begin
               install   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:   state_nxt = PREF;
         PREF:   state_nxt = hit ? IDLE : PWALK;
         PWALK: begin
            if (walk_resp_valid) begin
               install     = 1'b1;
               install_vpn = pf_vpn;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         valid   <= '0;
         vptr    <= '0;
         cur_vpn <= '0;
         ppn_q   <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && req_valid) cur_vpn <= req_vpn;
         if (state == WALK && walk_resp_valid) ppn_q <= walk_resp_ppn;
         if (install) begin
            valid[vptr] <= 1'b1;
            vptr        <= vptr + 1'b1;
         end
      end
   end

   // NOTE: the tag/data arrays are not reset; the valid bits alone qualify them.
   always_ff @(posedge clk) begin
      if (install) begin
         vpn_mem[vptr] <= install_vpn;
         ppn_mem[vptr] <= walk_resp_ppn;
      end
   end

   assign req_ready         = (state == IDLE);
   assign tlb_hit           = (state == LOOKUP) && hit;
   assign tlb_miss          = (state == LOOKUP) && !hit;
   assign tlb_prefetch      = (state == PREF) && !hit;
   assign resp_valid        = tlb_hit || (state == RESP);
   assign resp_ppn          = tlb_hit ? hit_ppn : (state == RESP) ? ppn_q : '0;
   assign walk_req_valid    = (state == WALK) || (state == PWALK);
   assign walk_req_prefetch = (state == PWALK);
   assign walk_req_vpn      = (state == WALK)  ? cur_vpn :
                              (state == PWALK) ? pf_vpn  : '0;

endmodule
